// File: rtl/router_pkg.sv
// Shared state encoding, header layout and helpers
// for the 3x1 router ingress controller.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    LOAD_PARITY,
    DROP
  } state_t;

  localparam int NPORT    = 3;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;
  localparam int CNT_W    = LEN_W + 1;

  localparam logic [ADDR_W-1:0] INVALID_DEST = 2'd3;

  // Unused dest code maps to no FIFO at all.
  function automatic logic [NPORT-1:0] dest_onehot(
    input logic [ADDR_W-1:0] d
  );
    logic [NPORT-1:0] v;
    for (int i = 0; i < NPORT; i++) begin
      v[i] = (d == ADDR_W'(i));
    end
    return v;
  endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-FIFO stall watchdog: counts idle read cycles on a
// non-empty FIFO and emits a one-cycle flush pulse.
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic i_fifo_empty,
  input  logic i_read_enb,
  output logic o_soft_reset
);

  logic [4:0] r_tcnt;
  logic       w_hit;

  assign w_hit = (r_tcnt == 5'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (i_fifo_empty || i_read_enb || w_hit) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 5'd1;
    end
  end

  assign o_soft_reset = w_hit;

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router ingress controller: header decode, FIFO select,
// write sequencing, parity check and stall flush handling.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  input  logic [NPORT-1:0]  fifo_full,
  input  logic [NPORT-1:0]  fifo_empty,
  input  logic [NPORT-1:0]  read_enb,
  output logic [NPORT-1:0]  write_enb,
  output logic [DATA_W-1:0] data_to_fifo,
  output logic              lfd_state,
  output logic [NPORT-1:0]  soft_reset,
  output logic              err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_dest;
  logic [LEN_W-1:0]  r_len_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [DATA_W-1:0] r_parity;
  logic [DATA_W-1:0] r_hdr;
  logic              r_err;

  logic [ADDR_W-1:0] w_hdr_dest;
  logic [LEN_W-1:0]  w_hdr_len;
  logic [NPORT-1:0]  w_hdr_sel;
  logic [NPORT-1:0]  w_sel;
  logic [NPORT-1:0]  w_sr;
  logic              w_hdr_empty;
  logic              w_full;
  logic              w_empty;
  logic              w_sr_dest;
  logic              w_abort;
  logic              w_busy;
  logic              w_accept;
  logic              w_wr;
  logic              w_lfd;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_to
    router_timeout #(
      .TIMEOUT(TIMEOUT)
    ) u_to (
      .clk          (clk),
      .reset        (reset),
      .i_fifo_empty (fifo_empty[gi]),
      .i_read_enb   (read_enb[gi]),
      .o_soft_reset (w_sr[gi])
    );
  end

  assign w_hdr_dest  = data_in[ADDR_LSB +: ADDR_W];
  assign w_hdr_len   = data_in[LEN_LSB +: LEN_W];
  assign w_hdr_sel   = dest_onehot(w_hdr_dest);
  assign w_hdr_empty = |(fifo_empty & w_hdr_sel);

  assign w_sel     = dest_onehot(r_dest);
  assign w_full    = |(fifo_full & w_sel);
  assign w_empty   = |(fifo_empty & w_sel);
  assign w_sr_dest = |(w_sr & w_sel);

  // A flush of our FIFO holds the source for the abort cycle.
  assign w_abort = w_sr_dest &&
                   (r_state == WAIT_EMPTY ||
                    r_state == LOAD_DATA  ||
                    r_state == LOAD_PARITY);

  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      WAIT_EMPTY,
      LOAD_FIRST:  w_busy = 1'b1;
      LOAD_DATA,
      LOAD_PARITY: w_busy = w_full | w_abort;
      default:     w_busy = 1'b0;
    endcase
  end

  assign w_accept = pkt_valid & ~w_busy;
  assign w_lfd    = (r_state == LOAD_FIRST);

  always_comb begin
    w_wr = 1'b0;
    unique case (r_state)
      LOAD_FIRST:  w_wr = ~w_full;
      LOAD_DATA,
      LOAD_PARITY: w_wr = w_accept;
      default:     w_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dest     <= '0;
      r_len_cnt  <= '0;
      r_drop_cnt <= '0;
      r_parity   <= '0;
      r_hdr      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (pkt_valid) begin
            r_hdr     <= data_in;
            r_dest    <= w_hdr_dest;
            r_len_cnt <= w_hdr_len;
            r_parity  <= data_in;
            if (w_hdr_dest == INVALID_DEST) begin
              r_drop_cnt <= {1'b0, w_hdr_len} + CNT_W'(1);
              r_state    <= DROP;
            end else if (w_hdr_empty) begin
              r_state <= LOAD_FIRST;
            end else begin
              r_state <= WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (w_abort) begin
            r_drop_cnt <= {1'b0, r_len_cnt} + CNT_W'(1);
            r_state    <= DROP;
          end else if (w_empty) begin
            r_state <= LOAD_FIRST;
          end
        end
        LOAD_FIRST: begin
          if (w_wr) begin
            r_state <= (r_len_cnt == '0) ? LOAD_PARITY
                                         : LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (w_abort) begin
            r_drop_cnt <= {1'b0, r_len_cnt} + CNT_W'(1);
            r_state    <= DROP;
          end else if (w_accept) begin
            r_parity  <= r_parity ^ data_in;
            r_len_cnt <= r_len_cnt - LEN_W'(1);
            if (r_len_cnt == LEN_W'(1)) begin
              r_state <= LOAD_PARITY;
            end
          end
        end
        LOAD_PARITY: begin
          if (w_abort) begin
            r_drop_cnt <= CNT_W'(1);
            r_state    <= DROP;
          end else if (w_accept) begin
            r_err   <= (data_in != r_parity);
            r_state <= IDLE;
          end
        end
        DROP: begin
          if (w_accept) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            if (r_drop_cnt == CNT_W'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = w_busy;
  assign lfd_state    = w_lfd;
  assign write_enb    = w_wr ? w_sel : '0;
  assign data_to_fifo = !w_wr ? '0 :
                        w_lfd ? r_hdr : data_in;
  assign soft_reset   = w_sr;
  assign err          = r_err;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed self-checking bench for router_fsm_ctrl:
// packet writes, parity, drop, stalls, timeout, reset.
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic [7:0] data_to_fifo;
  logic       lfd_state;
  logic [2:0] soft_reset;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int viol    = 0;

  logic [11:0] wq[$];
  logic [11:0] exp[$];
  logic [11:0] got;

  always #5 clk = ~clk;

  router_fsm_ctrl #(
    .DATA_W(8),
    .TIMEOUT(30)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .read_enb     (read_enb),
    .write_enb    (write_enb),
    .data_to_fifo (data_to_fifo),
    .lfd_state    (lfd_state),
    .soft_reset   (soft_reset),
    .err          (err)
  );

  // Write log entry: {lfd, one-hot port, byte}.
  always @(negedge clk) begin
    if (|write_enb)
      wq.push_back({lfd_state, write_enb, data_to_fifo});
    if (err) err_cnt++;
    if (!$onehot0(write_enb) || |(write_enb & fifo_full))
      viol++;
  end

  function automatic logic [11:0] W(
    input logic l, input int p, input logic [7:0] d
  );
    return {l, 3'(1 << p), d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(
    input logic [7:0] d, output int waits
  );
    bit done;
    done = 1'b0;
    waits = 0;
    pkt_valid = 1'b1;
    data_in = d;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else waits++;
      step();
    end
    pkt_valid = 1'b0;
    n_tests++; if (!done) begin
      n_fail++; $display("FAIL send_accept got busy=%b need 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    repeat (3) step();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got %b need 0", busy); end
    n_tests++; if (write_enb !== 3'b000) begin
      n_fail++; $display("FAIL rst_we got %b need 000", write_enb); end
    n_tests++; if (lfd_state !== 1'b0) begin
      n_fail++; $display("FAIL rst_lfd got %b need 0", lfd_state); end
    n_tests++; if (data_to_fifo !== 8'h00) begin
      n_fail++; $display("FAIL rst_dtf got %h need 00", data_to_fifo); end
    n_tests++; if (soft_reset !== 3'b000) begin
      n_fail++; $display("FAIL rst_sr got %b need 000", soft_reset); end
    n_tests++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL rst_err got %b need 0", err); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_good_packet();
    logic [7:0] b[5];
    int w;
    b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    wq.delete(); err_cnt = 0;
    for (int i = 0; i < 5; i++) send_byte(b[i], w);
    repeat (2) step();
    exp = '{W(1,1,8'h0D), W(0,1,8'h11), W(0,1,8'h22),
            W(0,1,8'h33), W(0,1,8'h0D)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL good_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL good_wr%0d got %h need %h", i, got, exp[i]); end
    end
    n_tests++; if (err_cnt != 0) begin
      n_fail++; $display("FAIL good_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_bad_parity();
    int w;
    wq.delete(); err_cnt = 0;
    send_byte(8'h0D, w); send_byte(8'h11, w);
    send_byte(8'h22, w); send_byte(8'h33, w);
    send_byte(8'h00, w);
    @(negedge clk);
    n_tests++; if (err !== 1'b1) begin
      n_fail++; $display("FAIL bad_err_pulse got %b need 1", err); end
    step();
    @(negedge clk);
    n_tests++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL bad_err_end got %b need 0", err); end
    step();
    n_tests++; if (err_cnt != 1) begin
      n_fail++; $display("FAIL bad_err_cycles got %0d need 1", err_cnt); end
    exp = '{W(1,1,8'h0D), W(0,1,8'h11), W(0,1,8'h22),
            W(0,1,8'h33), W(0,1,8'h00)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL bad_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL bad_wr%0d got %h need %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_drop();
    logic [7:0] b[4];
    int w;
    b = '{8'h0B, 8'h01, 8'h02, 8'h03};
    wq.delete(); err_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(b[i], w);
      n_tests++; if (w != 0) begin
        n_fail++; $display("FAIL drop_busy%0d got %0d waits need 0", i, w); end
    end
    n_tests++; if (wq.size() != 0) begin
      n_fail++; $display("FAIL drop_nwr got %0d need 0", wq.size()); end
    send_byte(8'h06, w); send_byte(8'hA5, w);
    send_byte(8'h06 ^ 8'hA5, w);
    repeat (2) step();
    exp = '{W(1,2,8'h06), W(0,2,8'hA5), W(0,2,8'hA3)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL drop_next_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL drop_next_wr%0d got %h need %h", i, got, exp[i]); end
    end
    n_tests++; if (err_cnt != 0) begin
      n_fail++; $display("FAIL drop_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_wait_empty();
    int w;
    wq.delete();
    fifo_empty = 3'b110;
    pkt_valid = 1'b1; data_in = 8'h04;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL we_hdr_busy got %b need 0", busy); end
    step();
    data_in = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (busy !== 1'b1 || write_enb !== 3'b000) begin
        n_fail++; $display("FAIL we_hold%0d got busy=%b we=%b need 1/000", k, busy, write_enb); end
      step();
    end
    fifo_empty = 3'b111;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || write_enb !== 3'b000) begin
      n_fail++; $display("FAIL we_rise got busy=%b we=%b need 1/000", busy, write_enb); end
    step();
    @(negedge clk);
    n_tests++; if (write_enb !== 3'b001 || lfd_state !== 1'b1 || data_to_fifo !== 8'h04) begin
      n_fail++; $display("FAIL we_hdr_wr got we=%b lfd=%b d=%h need 001/1/04", write_enb, lfd_state, data_to_fifo); end
    step();
    send_byte(8'h5A, w);
    send_byte(8'h04 ^ 8'h5A, w);
    repeat (2) step();
    exp = '{W(1,0,8'h04), W(0,0,8'h5A), W(0,0,8'h5E)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL we_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL we_wr%0d got %h need %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_full_stall();
    int w;
    wq.delete(); err_cnt = 0;
    send_byte(8'h0E, w);
    send_byte(8'h10, w);
    pkt_valid = 1'b1; data_in = 8'h20; fifo_full = 3'b100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (busy !== 1'b1 || write_enb !== 3'b000) begin
        n_fail++; $display("FAIL full_hold%0d got busy=%b we=%b need 1/000", k, busy, write_enb); end
      step();
    end
    fifo_full = 3'b000;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || write_enb !== 3'b100 || data_to_fifo !== 8'h20) begin
      n_fail++; $display("FAIL full_rel got busy=%b we=%b d=%h need 0/100/20", busy, write_enb, data_to_fifo); end
    step();
    send_byte(8'h30, w);
    send_byte(8'h0E ^ 8'h10 ^ 8'h20 ^ 8'h30, w);
    repeat (2) step();
    exp = '{W(1,2,8'h0E), W(0,2,8'h10), W(0,2,8'h20),
            W(0,2,8'h30), W(0,2,8'h0E)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL full_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL full_wr%0d got %h need %h", i, got, exp[i]); end
    end
    n_tests++; if (err_cnt != 0) begin
      n_fail++; $display("FAIL full_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_timeout();
    int first, hits, other;
    first = 0; hits = 0; other = 0;
    fifo_empty = 3'b101;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (soft_reset[1]) begin
        hits++;
        if (first == 0) first = k;
      end
      if (soft_reset[0] || soft_reset[2]) other++;
      step();
    end
    n_tests++; if (first != 30) begin
      n_fail++; $display("FAIL to_cycle got %0d need 30", first); end
    n_tests++; if (hits != 1) begin
      n_fail++; $display("FAIL to_width got %0d need 1", hits); end
    n_tests++; if (other != 0) begin
      n_fail++; $display("FAIL to_other got %0d need 0", other); end
    fifo_empty = 3'b111;
    step();
    first = 0; hits = 0;
    fifo_empty = 3'b101;
    for (int k = 1; k <= 51; k++) begin
      read_enb = (k == 20) ? 3'b010 : 3'b000;
      @(negedge clk);
      if (soft_reset[1]) begin
        hits++;
        if (first == 0) first = k;
      end
      step();
    end
    read_enb = 3'b000;
    fifo_empty = 3'b111;
    step();
    n_tests++; if (first != 50) begin
      n_fail++; $display("FAIL to_restart got %0d need 50", first); end
    n_tests++; if (hits != 1) begin
      n_fail++; $display("FAIL to_restart_width got %0d need 1", hits); end
  endtask

  task automatic test_abort();
    int w;
    bit seen;
    seen = 1'b0;
    wq.delete(); err_cnt = 0;
    send_byte(8'h0D, w);
    send_byte(8'h11, w);
    fifo_empty = 3'b101;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (soft_reset[1]) begin
        seen = 1'b1;
        n_tests++; if (busy !== 1'b1) begin
          n_fail++; $display("FAIL abort_busy got %b need 1", busy); end
      end
      step();
    end
    fifo_empty = 3'b111;
    n_tests++; if (!seen) begin
      n_fail++; $display("FAIL abort_pulse got 0 need 1"); end
    send_byte(8'h22, w);
    send_byte(8'h33, w);
    send_byte(8'h0D, w);
    send_byte(8'h06, w); send_byte(8'hA5, w);
    send_byte(8'hA3, w);
    repeat (2) step();
    exp = '{W(1,1,8'h0D), W(0,1,8'h11), W(1,2,8'h06),
            W(0,2,8'hA5), W(0,2,8'hA3)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL abort_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL abort_wr%0d got %h need %h", i, got, exp[i]); end
    end
    n_tests++; if (err_cnt != 0) begin
      n_fail++; $display("FAIL abort_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int w;
    send_byte(8'h0D, w);
    send_byte(8'h11, w);
    pkt_valid = 1'b1; data_in = 8'h22; reset = 1'b1;
    step();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || write_enb !== 3'b000 || lfd_state !== 1'b0) begin
      n_fail++; $display("FAIL mid_ctl got busy=%b we=%b lfd=%b need 0/000/0", busy, write_enb, lfd_state); end
    n_tests++; if (data_to_fifo !== 8'h00 || err !== 1'b0 || soft_reset !== 3'b000) begin
      n_fail++; $display("FAIL mid_out got d=%h err=%b sr=%b need 00/0/000", data_to_fifo, err, soft_reset); end
    pkt_valid = 1'b0; reset = 1'b0;
    step();
    wq.delete(); err_cnt = 0;
    send_byte(8'h0D, w); send_byte(8'h11, w);
    send_byte(8'h22, w); send_byte(8'h33, w);
    send_byte(8'h0D, w);
    repeat (2) step();
    exp = '{W(1,1,8'h0D), W(0,1,8'h11), W(0,1,8'h22),
            W(0,1,8'h33), W(0,1,8'h0D)};
    n_tests++; if (wq.size() != exp.size()) begin
      n_fail++; $display("FAIL mid_nwr got %0d need %0d", wq.size(), exp.size()); end
    foreach (exp[i]) begin
      got = (i < wq.size()) ? wq[i] : 12'hxxx;
      n_tests++; if (got !== exp[i]) begin
        n_fail++; $display("FAIL mid_wr%0d got %h need %h", i, got, exp[i]); end
    end
    n_tests++; if (err_cnt != 0) begin
      n_fail++; $display("FAIL mid_err got %0d need 0", err_cnt); end
  endtask

  task automatic test_invariants();
    n_tests++; if (viol != 0) begin
      n_fail++; $display("FAIL we_rules got %0d bad cycles need 0", viol); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_drop();
    test_wait_empty();
    test_full_stall();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish need finish");
    $fatal(1);
  end

endmodule
